// File: rtl/rgb_cmp_pwm_pkg.sv
// Shared types for the compare-to-RGB block: comparison codes, FSM states
// and the encoder that turns unsigned compare flags into a result code.
package rgb_pkg;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_LT   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_GT   = 2'b11
  } cmp_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_SHOW   = 2'b10
  } state_e;

  // lt has priority; with neither flag set the operands must be A>B
  function automatic cmp_e cmp_encode(input logic lt, input logic eq);
    cmp_e res;
    if (lt) begin
      res = CMP_LT;
    end else if (eq) begin
      res = CMP_EQ;
    end else begin
      res = CMP_GT;
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_cmp_pwm_if.sv
// Operand handshake, brightness request and LED/result outputs of rgb_cmp_pwm.
// master = switch/debounce side, slave = the compare block.
interface rgb_cmp_pwm_if #(
  parameter int WIDTH    = 4,
  parameter int PWM_BITS = 8
);
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                in_valid;
  logic                in_ready;
  logic [PWM_BITS-1:0] duty;
  logic [1:0]          result;
  logic                r;
  logic                g;
  logic                bl;

  modport master (
    output a, b, in_valid, duty,
    input  in_ready, result, r, g, bl
  );

  modport slave (
    input  a, b, in_valid, duty,
    output in_ready, result, r, g, bl
  );
endinterface

// File: rtl/rgb_pwm_gen.sv
// Free-running PWM counter with a brightness register that only reloads at the
// period wrap, so a duty change never cuts a period short.
module rgb_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] cnt_r;
  logic [PWM_BITS-1:0] duty_q_r;
  logic                wrap_s;

  assign wrap_s = (cnt_r == {PWM_BITS{1'b1}});

  // period counter and wrap-aligned duty capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= {PWM_BITS{1'b0}};
      duty_q_r <= {PWM_BITS{1'b0}};
    end else begin
      cnt_r <= cnt_r + PWM_BITS'(1);
      if (wrap_s) begin
        duty_q_r <= duty;
      end
    end
  end

  assign pwm_on = (cnt_r < duty_q_r);

endmodule

// File: rtl/rgb_cmp_pwm.sv
// Unsigned A/B comparator behind a valid/ready handshake, showing the held result
// as one PWM-dimmed RGB channel. Define RGB_CMP_BLINK_EN to make the EQ colour blink.
module rgb_cmp_pwm
  import rgb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 24
) (
  input logic          clk,
  input logic          reset,
  rgb_cmp_pwm_if.slave bus
);

  if (WIDTH < 1 || PWM_BITS < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("rgb_cmp_pwm: WIDTH, PWM_BITS and BLINK_DIV must all be >= 1");
  end

  state_e           state_r;
  state_e           state_next_s;
  logic             in_ready_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  cmp_e             cmp_r;
  cmp_e             result_r;
  logic             pend_r;
  logic             capture_s;
  logic             pwm_on_s;
  logic             blink_s;
  logic             r_r;
  logic             g_r;
  logic             bl_r;

  assign capture_s = bus.in_valid & in_ready_r;

  // next-state: SETTLE always lasts one cycle, SHOW is only left by a new capture
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (capture_s) begin
          state_next_s = S_SETTLE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_SETTLE: begin
        state_next_s = S_SHOW;
      end
      S_SHOW: begin
        if (capture_s) begin
          state_next_s = S_SETTLE;
        end else begin
          state_next_s = S_SHOW;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // state register; ready is registered from the next state so it drops exactly for SETTLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s != S_SETTLE);
    end
  end

  // operand capture on handshake only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= {WIDTH{1'b0}};
      b_r <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      a_r <= bus.a;
      b_r <= bus.b;
    end
  end

  // compare in SETTLE, publish one edge later: handshake edge t -> result on edge t+2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_r    <= CMP_NONE;
      pend_r   <= 1'b0;
      result_r <= CMP_NONE;
    end else begin
      pend_r <= (state_r == S_SETTLE);
      if (state_r == S_SETTLE) begin
        cmp_r <= cmp_encode(a_r < b_r, a_r == b_r);
      end
      if (pend_r) begin
        result_r <= cmp_r;
      end
    end
  end

  rgb_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .duty   (bus.duty),
    .pwm_on (pwm_on_s)
  );

`ifdef RGB_CMP_BLINK_EN
  logic [BLINK_DIV-1:0] blink_cnt_r;

  // blink phase counter; MSB low for the first half period after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r <= {BLINK_DIV{1'b0}};
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_DIV'(1);
    end
  end

  assign blink_s = blink_cnt_r[BLINK_DIV-1];
`else
  assign blink_s = 1'b1;
`endif

  // registered LED drives: at most one channel can be lit for a given result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r  <= 1'b0;
      g_r  <= 1'b0;
      bl_r <= 1'b0;
    end else begin
      r_r  <= pwm_on_s & (result_r == CMP_LT);
      g_r  <= pwm_on_s & (result_r == CMP_EQ) & blink_s;
      bl_r <= pwm_on_s & (result_r == CMP_GT);
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.result   = result_r;
  assign bus.r        = r_r;
  assign bus.g        = g_r;
  assign bus.bl       = bl_r;

endmodule

// File: tb/tb_rgb_cmp_pwm.sv
// Directed bench for rgb_cmp_pwm: table of compare/brightness vectors plus
// hand-written sequences for held valid, mid-period duty change and reset in SETTLE.
module tb_rgb_cmp_pwm;
  import rgb_pkg::*;

  localparam int WIDTH     = 4;
  localparam int PWM_BITS  = 8;
  localparam int BLINK_DIV = 4;
  localparam int PERIOD    = 256;
`ifdef RGB_CMP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rgb_cmp_pwm_if #(.WIDTH(WIDTH), .PWM_BITS(PWM_BITS)) bus ();

  rgb_cmp_pwm #(
    .WIDTH     (WIDTH),
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] duty;
    logic [1:0] res;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected lit cycles per period for channel ch (0=r,1=g,2=bl)
  function automatic int exp_on(input int d, input logic [1:0] res, input int ch);
    int n;
    int c;
    n = 0;
    if (res == 2'b00 || (int'(res) - 1) != ch) return 0;
    for (int i = 0; i < PERIOD; i++) begin
      c = i;
      if (i < d && (ch != 1 || !BLINK || c[BLINK_DIV-1])) n++;
    end
    return n;
  endfunction

  task automatic count_window(input int len, output int nr, output int ng, output int nb);
    nr = 0; ng = 0; nb = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      nr += int'(bus.r);
      ng += int'(bus.g);
      nb += int'(bus.bl);
    end
  endtask

  task automatic handshake(input logic [3:0] a, input logic [3:0] b);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int nr, ng, nb, bad;
    logic [1:0] prev;
    logic prev_r;
    bit found;

    vecs[0] = '{4'd3,  4'd9,  8'd128, 2'b01};
    vecs[1] = '{4'd15, 4'd15, 8'd200, 2'b10};
    vecs[2] = '{4'd12, 4'd4,  8'd64,  2'b11};
    vecs[3] = '{4'd0,  4'd0,  8'd255, 2'b10};
    vecs[4] = '{4'd15, 4'd0,  8'd1,   2'b11};
    vecs[5] = '{4'd7,  4'd7,  8'd255, 2'b10};
    vecs[6] = '{4'd0,  4'd15, 8'd0,   2'b01};

    reset = 1'b1;
    bus.a = 4'd0;
    bus.b = 4'd0;
    bus.in_valid = 1'b0;
    bus.duty = 8'd0;
    repeat (3) tick();
    check("rst_result", int'(bus.result), 0);
    check("rst_ready", int'(bus.in_ready), 1);
    reset = 1'b0;

    // idle after reset: nothing lit, ready held, no result
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.result != 2'b00 || bus.r || bus.g || bus.bl || !bus.in_ready) bad++;
    end
    check("idle_300", bad, 0);

    prev = 2'b00;
    for (int i = 0; i < 7; i++) begin
      bus.duty = vecs[i].duty;
      handshake(vecs[i].a, vecs[i].b);
      tick();
      check($sformatf("v%0d_hold", i), int'(bus.result), int'(prev));
      tick();
      check($sformatf("v%0d_result", i), int'(bus.result), int'(vecs[i].res));
      prev = vecs[i].res;
      repeat (PERIOD + 4) tick();
      count_window(PERIOD, nr, ng, nb);
      check($sformatf("v%0d_r_cnt", i), nr, exp_on(int'(vecs[i].duty), vecs[i].res, 0));
      check($sformatf("v%0d_g_cnt", i), ng, exp_on(int'(vecs[i].duty), vecs[i].res, 1));
      check($sformatf("v%0d_bl_cnt", i), nb, exp_on(int'(vecs[i].duty), vecs[i].res, 2));
    end

    // in_valid held high: EQ then GT, ready low only in SETTLE
    bus.a = 4'd15; bus.b = 4'd15; bus.in_valid = 1'b1;
    tick();
    check("hv_ready_settle1", int'(bus.in_ready), 0);
    bus.a = 4'd12; bus.b = 4'd4;
    tick();
    check("hv_ready_show1", int'(bus.in_ready), 1);
    tick();
    check("hv_result_eq", int'(bus.result), int'(CMP_EQ));
    check("hv_ready_settle2", int'(bus.in_ready), 0);
    tick();
    check("hv_ready_show2", int'(bus.in_ready), 1);
    check("hv_eq_hold", int'(bus.result), int'(CMP_EQ));
    bus.in_valid = 1'b0;
    tick();
    check("hv_result_gt", int'(bus.result), int'(CMP_GT));
    bus.a = 4'd0; bus.b = 4'd15;
    repeat (5) tick();
    check("no_hs_ignored", int'(bus.result), int'(CMP_GT));

    // duty change mid-period: old duty finishes the period
    bus.duty = 8'd128;
    handshake(4'd3, 4'd9);
    repeat (2 * PERIOD + 8) tick();
    found = 1'b0;
    prev_r = bus.r;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (!prev_r && bus.r) found = 1'b1;
      prev_r = bus.r;
    end
    check("dc_sync_found", int'(found), 1);
    repeat (99) tick();
    bus.duty = 8'd255;
    count_window(156, nr, ng, nb);
    check("dc_old_tail", nr, 28);
    count_window(PERIOD, nr, ng, nb);
    check("dc_new_full", nr, 255);
    bus.duty = 8'd0;
    repeat (PERIOD) tick();
    count_window(PERIOD, nr, ng, nb);
    check("dc_zero_r", nr, 0);
    check("dc_zero_gbl", ng + nb, 0);

    // reset during SETTLE discards the pending capture
    handshake(4'd1, 4'd2);
    check("rs_in_settle", int'(bus.in_ready), 0);
    reset = 1'b1;
    #1;
    check("rs_result_async", int'(bus.result), 0);
    check("rs_ready_async", int'(bus.in_ready), 1);
    check("rs_leds_async", int'(bus.r) + int'(bus.g) + int'(bus.bl), 0);
    tick();
    tick();
    reset = 1'b0;
    bus.duty = 8'd255;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.result != 2'b00 || bus.r || bus.g || bus.bl) bad++;
    end
    check("rs_stays_none", bad, 0);
    handshake(4'd1, 4'd2);
    tick();
    tick();
    check("rs_next_hs", int'(bus.result), int'(CMP_LT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
